// File: rtl/qam_pkg.sv
// Shared 16-QAM definitions: frame states, header magic and Gray axis labels.
// The transmit mapper uses the same label constants.
package qam_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int IN_WL      = 22;
    localparam int IN_IL      = 7;

    localparam logic [15:0] HDR_MAGIC = 16'hFFFF;

    // Per-axis labels, Gray-coded so adjacent levels differ by one bit
    localparam logic [1:0] L_M3 = 2'b00;
    localparam logic [1:0] L_M1 = 2'b01;
    localparam logic [1:0] L_P1 = 2'b11;
    localparam logic [1:0] L_P3 = 2'b10;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        SYM  = 2'd1,
        PASS = 2'd2
    } state_t;

endpackage

// File: rtl/qam_slice.sv
// One-axis hard-decision slicer for 16-QAM. Decision boundaries sit at
// -2.0, 0 and +2.0; a value exactly on a boundary belongs to the region above.
module qam_slice
    import qam_pkg::*;
#(
    parameter int IN_WL = 22,
    parameter int IN_IL = 7
) (
    input  logic [IN_WL-1:0] v,
    output logic [1:0]       label
);

    localparam int FB = IN_WL - IN_IL;
    localparam logic signed [IN_WL-1:0] T_POS = IN_WL'(2 << FB);
    localparam logic signed [IN_WL-1:0] T_NEG = IN_WL'(-(2 << FB));

    logic signed [IN_WL-1:0] sv;

    assign sv = v;

    // Pick the decision region for this component
    always_comb begin
        label = L_P3;
        if (sv < T_NEG) begin
            label = L_M3;
        end else if (sv[IN_WL-1]) begin
            label = L_M1;
        end else if (sv < T_POS) begin
            label = L_P1;
        end
    end

endmodule

// File: rtl/qam_demap.sv
// 16-QAM receive demapper. Header words pass through; symbol words are
// sliced per axis into a {Q, I} label nibble. One output register plus one
// skid entry give full throughput with a registered s_axis_ready.
//
// Build option: QAM_DEMAP_PACK_EN packs 16 symbol nibbles per output word
// (symbol k in bits [4k+3:4k]); a short final group is flushed on last.
//
// state | meaning
// HDR   | expecting a frame header word
// SYM   | symbol payload, words are sliced
// PASS  | non-symbol payload, words forwarded unchanged
module qam_demap
    import qam_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int IN_WL      = 22,
    parameter int IN_IL      = 7
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset_n,
    input  logic                  s_axis_valid,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_last,
    output logic                  s_axis_ready,
    output logic                  m_axis_valid,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_last,
    input  logic                  m_axis_ready
);

    state_t                state, state_nxt;
    logic                  accept;
    logic [1:0]            lab_i, lab_q;
    logic [3:0]            nib;
    logic                  emit;
    logic [DATA_WIDTH-1:0] word;

    logic                  out_valid, out_last;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  skid_valid, skid_last;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  in_ready;
    logic                  out_free;

`ifdef QAM_DEMAP_PACK_EN
    logic [DATA_WIDTH-1:0] pack_acc, pack_acc_nxt, pack_merged;
    logic [3:0]            pack_cnt, pack_cnt_nxt;
`endif

    assign accept   = s_axis_valid & in_ready;
    assign out_free = ~out_valid | m_axis_ready;
    assign nib      = {lab_q, lab_i};

    qam_slice #(.IN_WL(IN_WL), .IN_IL(IN_IL)) u_slice_i (
        .v     (s_axis_data[IN_WL-1:0]),
        .label (lab_i)
    );

    qam_slice #(.IN_WL(IN_WL), .IN_IL(IN_IL)) u_slice_q (
        .v     (s_axis_data[32+IN_WL-1:32]),
        .label (lab_q)
    );

    // Frame state register
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state <= HDR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the word produced by the current input, if any
    always_comb begin
        state_nxt = state;
        emit      = accept;
        word      = s_axis_data;
`ifdef QAM_DEMAP_PACK_EN
        pack_acc_nxt = pack_acc;
        pack_cnt_nxt = pack_cnt;
        pack_merged  = pack_acc | (DATA_WIDTH'(nib) << {pack_cnt, 2'b00});
`endif
        case (state)
            HDR: begin
                if (accept && !s_axis_last) begin
                    state_nxt = (s_axis_data[DATA_WIDTH-1 -: 16] == HDR_MAGIC) ? SYM : PASS;
                end
            end
            SYM: begin
`ifdef QAM_DEMAP_PACK_EN
                emit = 1'b0;
                word = pack_merged;
                if (accept) begin
                    if (pack_cnt == 4'd15 || s_axis_last) begin
                        emit         = 1'b1;
                        pack_acc_nxt = '0;
                        pack_cnt_nxt = 4'd0;
                    end else begin
                        pack_acc_nxt = pack_merged;
                        pack_cnt_nxt = pack_cnt + 4'd1;
                    end
                end
`else
                word = {{(DATA_WIDTH-4){1'b0}}, nib};
`endif
                if (accept && s_axis_last) begin
                    state_nxt = HDR;
                end
            end
            PASS: begin
                if (accept && s_axis_last) begin
                    state_nxt = HDR;
                end
            end
            default: state_nxt = HDR;
        endcase
    end

`ifdef QAM_DEMAP_PACK_EN
    // Nibble accumulator for packed symbol output
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            pack_acc <= '0;
            pack_cnt <= 4'd0;
        end else begin
            pack_acc <= pack_acc_nxt;
            pack_cnt <= pack_cnt_nxt;
        end
    end
`endif

    // Output register with one skid entry; ready tracks skid emptiness
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
            in_ready   <= 1'b1;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                out_last   <= skid_last;
                skid_valid <= 1'b0;
                in_ready   <= 1'b1;
            end else if (emit) begin
                out_valid <= 1'b1;
                out_data  <= word;
                out_last  <= s_axis_last;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (emit) begin
            // Output stalled: ready was high, so the skid entry is free
            skid_valid <= 1'b1;
            skid_data  <= word;
            skid_last  <= s_axis_last;
            in_ready   <= 1'b0;
        end
    end

    assign s_axis_ready = in_ready;
    assign m_axis_valid = out_valid;
    assign m_axis_data  = out_data;
    assign m_axis_last  = out_last;

endmodule

// File: tb/tb_qam_demap.sv
// Self-checking bench for qam_demap: threshold table, pass-through frames,
// backpressure, reset mid-frame, and packed output when QAM_DEMAP_PACK_EN is set.
module tb_qam_demap;
    import qam_pkg::*;

    logic        axi_clk = 1'b0;
    logic        axi_reset_n;
    logic        s_axis_valid;
    logic [63:0] s_axis_data;
    logic        s_axis_last;
    logic        s_axis_ready;
    logic        m_axis_valid;
    logic [63:0] m_axis_data;
    logic        m_axis_last;
    logic        m_axis_ready;

    int checks = 0;
    int errors = 0;

    logic [64:0] exp_q[$];

    // Reference model state (word level)
    int          mstate;
    logic [63:0] macc;
    int          mcnt;

    logic toggle_en = 1'b0;
    logic rdy_set   = 1'b1;

    logic        hold_v = 1'b0;
    logic [63:0] hold_d;
    logic        hold_l;
    logic        prev_stall = 1'b0;
    logic        prev_s_ready = 1'b1;

    typedef struct {
        logic [63:0] din;
        logic [3:0]  nib;
    } vec_t;
    vec_t tbl[10];

    always #5 axi_clk = ~axi_clk;

    qam_demap dut (
        .axi_clk      (axi_clk),
        .axi_reset_n  (axi_reset_n),
        .s_axis_valid (s_axis_valid),
        .s_axis_data  (s_axis_data),
        .s_axis_last  (s_axis_last),
        .s_axis_ready (s_axis_ready),
        .m_axis_valid (m_axis_valid),
        .m_axis_data  (m_axis_data),
        .m_axis_last  (m_axis_last),
        .m_axis_ready (m_axis_ready)
    );

    function automatic logic [1:0] ref_slice(input logic [21:0] v);
        int x;
        x = {{10{v[21]}}, v};
        if (x < -65536)     return 2'b00;
        else if (x < 0)     return 2'b01;
        else if (x < 65536) return 2'b11;
        else                return 2'b10;
    endfunction

    task automatic model_push(input logic [63:0] d, input logic l);
        logic [3:0] nb;
        case (mstate)
            0: begin
                exp_q.push_back({l, d});
                if (!l) mstate = (d[63:48] == 16'hFFFF) ? 1 : 2;
            end
            2: begin
                exp_q.push_back({l, d});
                if (l) mstate = 0;
            end
            default: begin
                nb = {ref_slice(d[53:32]), ref_slice(d[21:0])};
`ifdef QAM_DEMAP_PACK_EN
                macc[4*mcnt +: 4] = nb;
                mcnt++;
                if (mcnt == 16 || l) begin
                    exp_q.push_back({l, macc});
                    macc = '0;
                    mcnt = 0;
                end
`else
                exp_q.push_back({l, 60'b0, nb});
`endif
                if (l) mstate = 0;
            end
        endcase
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic send_raw(input logic [63:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        s_axis_data  = d;
        s_axis_last  = l;
        s_axis_valid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge axi_clk);
            if (s_axis_ready) ok = 1'b1;
            @(posedge axi_clk);
            #1;
        end
        s_axis_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout word=%h not accepted in 100 cycles", d);
        end
    endtask

    task automatic send(input logic [63:0] d, input logic l);
        model_push(d, l);
        send_raw(d, l);
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge axi_clk);
            if (exp_q.size() == 0 && !m_axis_valid) done = 1'b1;
        end
        @(posedge axi_clk);
        #1;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
        end
    endtask

    // Downstream ready: constant or toggling every cycle
    initial begin
        m_axis_ready = 1'b1;
        forever begin
            @(posedge axi_clk);
            #1;
            if (toggle_en) m_axis_ready = ~m_axis_ready;
            else           m_axis_ready = rdy_set;
        end
    end

    // Scoreboard, hold-stability and ready-drop checks
    always @(negedge axi_clk) begin
        logic [64:0] e;
        if (axi_reset_n) begin
            if (hold_v) begin
                checks++;
                if (!m_axis_valid || m_axis_data !== hold_d || m_axis_last !== hold_l) begin
                    errors++;
                    $display("FAIL hold actual=%b/%h/%b required=1/%h/%b",
                             m_axis_valid, m_axis_data, m_axis_last, hold_d, hold_l);
                end
            end
            if (m_axis_valid && m_axis_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out actual=%h/%b required=none", m_axis_data, m_axis_last);
                end else begin
                    e = exp_q.pop_front();
                    if (m_axis_data !== e[63:0] || m_axis_last !== e[64]) begin
                        errors++;
                        $display("FAIL out_word actual=%h/%b required=%h/%b",
                                 m_axis_data, m_axis_last, e[63:0], e[64]);
                    end
                end
            end
            if (prev_s_ready && !s_axis_ready) begin
                checks++;
                if (!prev_stall) begin
                    errors++;
                    $display("FAIL ready_drop actual=drop_without_stall required=stall_before_drop");
                end
            end
            hold_v       = m_axis_valid && !m_axis_ready;
            hold_d       = m_axis_data;
            hold_l       = m_axis_last;
            prev_stall   = hold_v;
            prev_s_ready = s_axis_ready;
        end else begin
            hold_v       = 1'b0;
            prev_stall   = 1'b0;
            prev_s_ready = 1'b1;
        end
    end

    initial begin
        tbl[0] = '{64'h0000_0000_0008_0000 | 64'h0000_0000_003E_8000 | (64'h0000_8000 << 32) & 64'hFFFF_FFFF_0000_0000, 4'hC};
        tbl[0].din = {32'h0000_8000, 32'h003E_8000};
        tbl[1] = '{{32'h0, 32'h003F_0000}, 4'hD};
        tbl[2] = '{{32'h0, 32'h0000_0000}, 4'hF};
        tbl[3] = '{{32'h0, 32'h0001_0000}, 4'hE};
        tbl[4] = '{{32'h0, 32'h003E_FFFF}, 4'hC};
        tbl[5] = '{{32'h0, 32'h0000_FFFF}, 4'hF};
        tbl[6] = '{{32'h003F_0000, 32'h0}, 4'h7};
        tbl[7] = '{{32'h0001_0000, 32'h0001_0000}, 4'hA};
        tbl[8] = '{{32'hFFC0_0000, 32'hFFC0_0000}, 4'hF};
        tbl[9] = '{{32'h0020_0000, 32'h001F_FFFF}, 4'h2};

        mstate = 0;
        macc   = '0;
        mcnt   = 0;
        s_axis_valid = 1'b0;
        s_axis_data  = '0;
        s_axis_last  = 1'b0;
        axi_reset_n  = 1'b0;
        repeat (3) @(posedge axi_clk);
        @(negedge axi_clk);
        axi_reset_n = 1'b1;
        @(negedge axi_clk);
        chk("rst_m_valid", {63'b0, m_axis_valid}, 64'd0);
        chk("rst_m_data",  m_axis_data, 64'd0);
        chk("rst_m_last",  {63'b0, m_axis_last}, 64'd0);
        chk("rst_s_ready", {63'b0, s_axis_ready}, 64'd1);
        @(posedge axi_clk);
        #1;

        // Threshold table: each vector is a one-symbol frame
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({1'b0, 64'hFFFF_0000_0000_0010});
            exp_q.push_back({1'b1, 60'b0, tbl[i].nib});
            send_raw(64'hFFFF_0000_0000_0010, 1'b0);
            send_raw(tbl[i].din, 1'b1);
        end
        wait_drain();

        // Non-symbol header: payload forwarded unchanged
        send(64'h1234_0000_0000_0000, 1'b0);
        send(64'h0000_0000_0001_8000, 1'b1);
        wait_drain();

        // Backpressure: ready toggling during an 8-symbol frame
        toggle_en = 1'b1;
        send(64'hFFFF_0000_0000_0008, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send({$urandom, $urandom}, i == 7);
        end
        toggle_en = 1'b0;
        rdy_set   = 1'b1;
        wait_drain();

        // 18-symbol frame (one full packed word plus a partial one)
        send(64'hFFFF_0000_0000_0012, 1'b0);
        for (int i = 0; i < 18; i++) begin
            send({10'b0, 22'($urandom), 10'b0, 22'($urandom)}, i == 17);
        end
        wait_drain();

        // Exactly 16 symbols, last on the 16th
        send(64'hFFFF_0000_0000_0010, 1'b0);
        for (int i = 0; i < 16; i++) begin
            send({$urandom, $urandom}, i == 15);
        end
        wait_drain();

        // Reset in the middle of a symbol frame with output stalled
        rdy_set = 1'b0;
        @(posedge axi_clk);
        #1;
        send(64'hFFFF_0000_0000_0004, 1'b0);
        send(64'h0000_8000_003E_8000, 1'b0);
        repeat (2) @(posedge axi_clk);
        @(negedge axi_clk);
        chk("pre_rst_valid", {63'b0, m_axis_valid}, 64'd1);
        #2;
        axi_reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'b0, m_axis_valid}, 64'd0);
        chk("mid_rst_data",  m_axis_data, 64'd0);
        chk("mid_rst_last",  {63'b0, m_axis_last}, 64'd0);
        chk("mid_rst_ready", {63'b0, s_axis_ready}, 64'd1);
        exp_q.delete();
        mstate = 0;
        macc   = '0;
        mcnt   = 0;
        rdy_set = 1'b1;
        repeat (2) @(posedge axi_clk);
        @(negedge axi_clk);
        axi_reset_n = 1'b1;
        @(posedge axi_clk);
        #1;
        send(64'h0000_0000_0001_8000, 1'b1);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
